mem_dp_pipe: RTL and testbench



---
 rtl/mem_dp_pipe_if.sv | 17 +
 rtl/mem_dp_pipe.sv | 121 ++++++++++++
 tb/tb_mem_dp_pipe.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_dp_pipe_if.sv
// One RAM port: request fields from the requester, read data/valid back to it.
interface mem_dp_pipe_if #(
    parameter int DATA_WIDTH = 290,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_BYTES  = (DATA_WIDTH + 7) / 8
);
    logic                  cs;
    logic                  we;
    logic [NUM_BYTES-1:0]  be;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  rvalid;

    modport master (output cs, we, be, address, data_in, input data_out, rvalid);
    modport slave  (input cs, we, be, address, data_in, output data_out, rvalid);
endinterface

// File: rtl/mem_dp_pipe.sv
// True dual-port RAM with byte enables, pipelined reads with valid strobes,
// write-write collision arbitration (port 0 wins per byte) and a post-reset clear.
module mem_dp_pipe #(
    parameter int DATA_WIDTH = 290,
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0,
    parameter int NUM_BYTES  = (DATA_WIDTH + 7) / 8
) (
    input  logic           clk,
    input  logic           reset_N,
    mem_dp_pipe_if.slave   p0,
    mem_dp_pipe_if.slave   p1,
    output logic           init_busy,
    output logic           collision
);
    typedef enum logic {CLEAR, READY} state_t;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(RAM_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                  collision_q, collision_d;

    logic                  cs   [2];
    logic                  we   [2];
    logic [NUM_BYTES-1:0]  be   [2];
    logic [ADDR_WIDTH-1:0] addr [2];
    logic [DATA_WIDTH-1:0] din  [2];

    logic [1:0]            wr, rd, in_rng;
    logic                  same_addr;
    logic [DATA_WIDTH-1:0] bmask [2];
    logic [DATA_WIDTH-1:0] wdata [2];
    logic [DATA_WIDTH-1:0] rdata [2];

    logic [1:0][RD_LATENCY-1:0]                 vld_pipe_q, vld_pipe_d;
    logic [1:0][RD_LATENCY-1:0][DATA_WIDTH-1:0] dat_pipe_q, dat_pipe_d;

    assign cs[0]   = p0.cs;      assign cs[1]   = p1.cs;
    assign we[0]   = p0.we;      assign we[1]   = p1.we;
    assign be[0]   = p0.be;      assign be[1]   = p1.be;
    assign addr[0] = p0.address; assign addr[1] = p1.address;
    assign din[0]  = p0.data_in; assign din[1]  = p1.data_in;

    assign init_busy = (state_q == CLEAR);
    assign collision = collision_q;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST) state_d = READY;
        end
    end

    always_comb begin
        same_addr = (addr[0] == addr[1]);
        for (int p = 0; p < 2; p++) begin
            in_rng[p] = 32'(addr[p]) < 32'(RAM_DEPTH);
            wr[p]     = !init_busy && cs[p] && we[p] && in_rng[p];
            rd[p]     = !init_busy && cs[p] && !we[p];
            for (int b = 0; b < DATA_WIDTH; b++) bmask[p][b] = be[p][b / 8];
            wdata[p]  = (mem[addr[p]] & ~bmask[p]) | (din[p] & bmask[p]);
        end
        // Same-address double write: lay port 0's bytes over port 1's merge.
        if (wr[0] && wr[1] && same_addr)
            wdata[0] = (wdata[1] & ~bmask[0]) | (din[0] & bmask[0]);
        collision_d = !init_busy && cs[0] && we[0] && cs[1] && we[1] && same_addr;
        for (int p = 0; p < 2; p++) begin
            rdata[p] = '0;
            if (in_rng[p])
                rdata[p] = (RDW_MODE != 0 && wr[1-p] && same_addr) ? wdata[1-p] : mem[addr[p]];
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            vld_pipe_d[p][0] = rd[p];
            dat_pipe_d[p][0] = rd[p] ? rdata[p] : '0;
            for (int s = 1; s < RD_LATENCY; s++) begin
                vld_pipe_d[p][s] = vld_pipe_q[p][s-1];
                dat_pipe_d[p][s] = dat_pipe_q[p][s-1];
            end
        end
    end

    // Array has no reset; the clear sequencer owns it until READY.
    always_ff @(posedge clk) begin
        if (init_busy) begin
            mem[clr_cnt_q] <= '0;
        end else begin
            if (wr[1] && !(wr[0] && same_addr)) mem[addr[1]] <= wdata[1];
            if (wr[0]) mem[addr[0]] <= wdata[0];
        end
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            collision_q <= 1'b0;
            vld_pipe_q  <= '0;
            dat_pipe_q  <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            collision_q <= collision_d;
            vld_pipe_q  <= vld_pipe_d;
            dat_pipe_q  <= dat_pipe_d;
        end
    end

    assign p0.rvalid   = vld_pipe_q[0][RD_LATENCY-1];
    assign p1.rvalid   = vld_pipe_q[1][RD_LATENCY-1];
    assign p0.data_out = dat_pipe_q[0][RD_LATENCY-1];
    assign p1.data_out = dat_pipe_q[1][RD_LATENCY-1];
endmodule

// File: tb/tb_mem_dp_pipe.sv
// Directed bench for mem_dp_pipe: two instances (old-data / new-data RDW) driven in lockstep.
module tb_mem_dp_pipe;
    logic clk = 1'b0;
    logic reset_N;
    logic busy_a, busy_b, coll_a, coll_b;
    int   npass = 0;
    int   ntot  = 0;
    logic seen_rv;
    int   cnt;
    logic [31:0] rdat;
    logic        rv;

    always #5 clk = ~clk;

    mem_dp_pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) ia0 ();
    mem_dp_pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) ia1 ();
    mem_dp_pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) ib0 ();
    mem_dp_pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) ib1 ();

    mem_dp_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RAM_DEPTH(16), .RD_LATENCY(2), .RDW_MODE(0)) dut_a (
        .clk(clk), .reset_N(reset_N), .p0(ia0), .p1(ia1), .init_busy(busy_a), .collision(coll_a));
    mem_dp_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RAM_DEPTH(16), .RD_LATENCY(2), .RDW_MODE(1)) dut_b (
        .clk(clk), .reset_N(reset_N), .p0(ib0), .p1(ib1), .init_busy(busy_b), .collision(coll_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic drive(input int p, input logic cs, input logic we, input logic [3:0] be,
                         input logic [3:0] a, input logic [31:0] d);
        if (p == 0) begin
            ia0.cs = cs; ia0.we = we; ia0.be = be; ia0.address = a; ia0.data_in = d;
            ib0.cs = cs; ib0.we = we; ib0.be = be; ib0.address = a; ib0.data_in = d;
        end else begin
            ia1.cs = cs; ia1.we = we; ia1.be = be; ia1.address = a; ia1.data_in = d;
            ib1.cs = cs; ib1.we = we; ib1.be = be; ib1.address = a; ib1.data_in = d;
        end
    endtask

    task automatic idle();
        drive(0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    endtask

    task automatic wr(input int p, input logic [3:0] be, input logic [3:0] a, input logic [31:0] d);
        drive(p, 1'b1, 1'b1, be, a, d);
        @(negedge clk);
        idle();
    endtask

    // Single read on dut_a; returns what appears two cycles after the request.
    task automatic rd1(input int p, input logic [3:0] a, output logic [31:0] dat, output logic v);
        drive(p, 1'b1, 1'b0, 4'h0, a, 32'h0);
        @(negedge clk);
        idle();
        @(negedge clk);
        dat = (p == 0) ? ia0.data_out : ia1.data_out;
        v   = (p == 0) ? ia0.rvalid   : ia1.rvalid;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy_a && n < 100) begin
            @(negedge clk);
            n++;
            seen_rv = seen_rv | ia1.rvalid | ib1.rvalid | ia0.rvalid;
        end
    endtask

    initial begin
        reset_N = 1'b0;
        seen_rv = 1'b0;
        idle();
        drive(1, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0);
        repeat (2) @(negedge clk);
        chk("rst_rvalid", {ia0.rvalid, ia1.rvalid}, 2'b00);
        chk("rst_dout", ia0.data_out | ia1.data_out, 32'h0);
        chk("rst_coll", coll_a, 1'b0);
        chk("rst_busy", {busy_a, busy_b}, 2'b11);

        // Clear length, with a read held throughout that must be ignored
        reset_N = 1'b1;
        count_busy(cnt);
        idle();
        chk("clear_len", cnt, 16);
        repeat (3) begin
            @(negedge clk);
            seen_rv = seen_rv | ia1.rvalid | ib1.rvalid;
        end
        chk("busy_gate", seen_rv, 1'b0);

        // Read every address on both ports, pipelined
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin
                drive(0, 1'b1, 1'b0, 4'h0, 4'(i), 32'h0);
                drive(1, 1'b1, 1'b0, 4'h0, 4'(15 - i), 32'h0);
            end else idle();
            @(negedge clk);
            if (i == 0) chk("rd_latency", {ia0.rvalid, ia1.rvalid}, 2'b00);
            else begin
                chk("clr_rvalid", {ia0.rvalid, ia1.rvalid}, 2'b11);
                chk("clr_data", ia0.data_out | ia1.data_out, 32'h0);
            end
        end
        @(negedge clk);
        chk("clr_drain", {ia0.rvalid, ia1.rvalid}, 2'b00);

        // Byte-enable merge, then a be=0 write that must not change anything
        wr(0, 4'hF, 4'd3, 32'hAABBCCDD);
        wr(0, 4'h5, 4'd3, 32'h11223344);
        rd1(0, 4'd3, rdat, rv);
        chk("be_merge_v", rv, 1'b1);
        chk("be_merge", rdat, 32'hAA22CC44);
        wr(0, 4'h0, 4'd3, 32'h0);
        rd1(1, 4'd3, rdat, rv);
        chk("be_zero", rdat, 32'hAA22CC44);

        // Back-to-back reads on port 1
        wr(0, 4'hF, 4'd0, 32'h10);
        wr(0, 4'hF, 4'd1, 32'h20);
        wr(0, 4'hF, 4'd2, 32'h30);
        drive(1, 1'b1, 1'b0, 4'h0, 4'd0, 32'h0);
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 4'h0, 4'd1, 32'h0);
        @(negedge clk);
        chk("b2b_0", {31'h0, ia1.rvalid} | (ia1.data_out << 1), (32'h10 << 1) | 32'h1);
        drive(1, 1'b1, 1'b0, 4'h0, 4'd2, 32'h0);
        @(negedge clk);
        chk("b2b_1", {31'h0, ia1.rvalid} | (ia1.data_out << 1), (32'h20 << 1) | 32'h1);
        idle();
        @(negedge clk);
        chk("b2b_2", {31'h0, ia1.rvalid} | (ia1.data_out << 1), (32'h30 << 1) | 32'h1);
        @(negedge clk);
        chk("b2b_end", ia1.rvalid, 1'b0);

        // Cross-port read-during-write
        wr(0, 4'hF, 4'd5, 32'h5);
        drive(0, 1'b1, 1'b1, 4'hF, 4'd5, 32'h99);
        drive(1, 1'b1, 1'b0, 4'h0, 4'd5, 32'h0);
        @(negedge clk);
        idle();
        @(negedge clk);
        chk("rdw_v", {ia1.rvalid, ib1.rvalid}, 2'b11);
        chk("rdw_old", ia1.data_out, 32'h5);
        chk("rdw_new", ib1.data_out, 32'h99);
        rd1(1, 4'd5, rdat, rv);
        chk("rdw_after", rdat, 32'h99);

        // Write-write collision
        drive(0, 1'b1, 1'b1, 4'b0001, 4'd7, 32'h000000FF);
        drive(1, 1'b1, 1'b1, 4'b1111, 4'd7, 32'hFFFFFF00);
        @(negedge clk);
        idle();
        chk("coll_pulse", {coll_a, coll_b}, 2'b11);
        @(negedge clk);
        chk("coll_clear", coll_a, 1'b0);
        rd1(0, 4'd7, rdat, rv);
        chk("coll_data", rdat, 32'hFFFFFFFF);
        wr(0, 4'b0010, 4'd7, 32'h00001200);
        rd1(0, 4'd7, rdat, rv);
        chk("coll_single", rdat, 32'hFFFF12FF);
        chk("coll_single_flag", coll_a, 1'b0);

        // Reset with reads in flight, then reset again mid-clear
        drive(0, 1'b1, 1'b0, 4'h0, 4'd3, 32'h0);
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 4'h0, 4'd7, 32'h0);
        @(negedge clk);
        idle();
        chk("pre_rst_data", ia0.data_out, 32'hAA22CC44);
        reset_N = 1'b0;
        #1;
        chk("rst_async_v", ia0.rvalid, 1'b0);
        chk("rst_async_d", ia0.data_out, 32'h0);
        chk("rst_async_busy", busy_a, 1'b1);
        @(negedge clk);
        reset_N = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        reset_N = 1'b0;
        #1;
        chk("rst_mid_busy", busy_a, 1'b1);
        @(negedge clk);
        reset_N = 1'b1;
        seen_rv = 1'b0;
        count_busy(cnt);
        chk("clear_len2", cnt, 16);
        chk("lost_reads", seen_rv, 1'b0);
        rd1(0, 4'd3, rdat, rv);
        chk("recleared_3", {rdat[30:0], rv}, 32'h1);
        rd1(1, 4'd7, rdat, rv);
        chk("recleared_7", rdat, 32'h0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
